// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem reads, hands instructions to the IF/ID register,
// and absorbs downstream stalls and redirects without losing or duplicating an address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read_o,
  output logic [31:0] imem_address_o,
  input  logic        imem_resp_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic        if_flush_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_SQUASH = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_sq_addr;
  logic [XLEN-1:0] r_buf_instr;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_sq_addr_nxt;
  logic [XLEN-1:0] w_buf_instr_nxt;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_target;
  logic            w_unused_lsb;

  assign w_pc_inc     = r_pc + XLEN'(4);
  assign w_target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_lsb = ^redirect_pc_i[1:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_sq_addr   <= '0;
      r_buf_instr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_sq_addr   <= w_sq_addr_nxt;
      r_buf_instr <= w_buf_instr_nxt;
    end
  end

  // Next state and zero-latency handoff to IF/ID
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_sq_addr_nxt   = r_sq_addr;
    w_buf_instr_nxt = r_buf_instr;
    imem_read_o     = 1'b0;
    imem_address_o  = r_pc;
    if_valid_o      = 1'b0;
    if_flush_o      = 1'b0;
    if_pc_o         = r_pc;
    if_instr_o      = r_buf_instr;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        imem_read_o = 1'b1;
        if_flush_o  = redirect_i;
        if_instr_o  = imem_rdata_i;
        if (redirect_i) begin
          w_pc_nxt = w_target;
          // Read still in flight: keep presenting its address until the response drains
          if (!imem_resp_i) begin
            w_sq_addr_nxt = r_pc;
            w_state_nxt   = S_SQUASH;
          end
        end else if (imem_resp_i) begin
          if (stall_i) begin
            w_buf_instr_nxt = imem_rdata_i;
            w_state_nxt     = S_HOLD;
          end else begin
            if_valid_o = 1'b1;
            w_pc_nxt   = w_pc_inc;
          end
        end
      end

      S_HOLD: begin
        if_flush_o = redirect_i;
        if (redirect_i) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!stall_i) begin
          if_valid_o  = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end

      S_SQUASH: begin
        imem_read_o    = 1'b1;
        imem_address_o = r_sq_addr;
        if_flush_o     = redirect_i;
        if (redirect_i) begin
          w_pc_nxt = w_target;
        end
        if (imem_resp_i) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-vector bench for fetch_unit: per-cycle handshake checks plus a scoreboard
// of delivered {pc, instr} pairs.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0060;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic        if_flush_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_read_o    (imem_read_o),
    .imem_address_o (imem_address_o),
    .imem_resp_i    (imem_resp_i),
    .imem_rdata_i   (imem_rdata_i),
    .if_valid_o     (if_valid_o),
    .if_flush_o     (if_flush_o),
    .if_pc_o        (if_pc_o),
    .if_instr_o     (if_instr_o)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                     input logic rs, input logic [31:0] dat, input logic e_rd,
                     input logic [31:0] e_ad, input logic e_v, input logic e_f,
                     input logic [31:0] e_pc, input logic [31:0] e_in);
    vec_t v;
    v.rst = r; v.stall = st; v.redir = rd; v.rpc = rpc; v.resp = rs; v.rdata = dat;
    v.e_read = e_rd; v.e_addr = e_ad; v.e_valid = e_v; v.e_flush = e_f;
    v.e_pc = e_pc; v.e_instr = e_in;
    vq.push_back(v);
  endtask

  initial begin
    exp_t e;

    // Reset held with redirect asserted: everything forced quiet
    #2 rst = 1'b0;
    redirect_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst_read",  c, 32'(imem_read_o), 32'd0);
      chk("rst_addr",  c, imem_address_o, RST_PC);
      chk("rst_valid", c, 32'(if_valid_o), 32'd0);
      chk("rst_flush", c, 32'(if_flush_o), 32'd0);
      chk("rst_pc",    c, if_pc_o, RST_PC);
      chk("rst_instr", c, if_instr_o, 32'd0);
    end
    redirect_i = 1'b0;

    //  rst st rd rpc            rs dat            rd ad            v  f  pc             instr
    // Reset release, single-cycle memory
    add(1, 0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            0);
    add(1, 0, 0, 0,            1, 32'h1111_0060, 1, 32'h4000_0060, 1, 0, 32'h4000_0060, 32'h1111_0060);
    // Stall three cycles on 4000_0064, then release from buffer
    add(1, 1, 0, 0,            1, 32'h2222_0064, 1, 32'h4000_0064, 0, 0, 0,            0);
    add(1, 1, 0, 0,            1, JUNK,         0, 0,            0, 0, 0,            0);
    add(1, 1, 0, 0,            0, 0,            0, 0,            0, 0, 0,            0);
    add(1, 0, 0, 0,            0, 0,            0, 0,            1, 0, 32'h4000_0064, 32'h2222_0064);
    add(1, 0, 0, 0,            1, 32'h3333_0068, 1, 32'h4000_0068, 1, 0, 32'h4000_0068, 32'h3333_0068);
    add(1, 0, 0, 0,            1, 32'h4444_006C, 1, 32'h4000_006C, 1, 0, 32'h4000_006C, 32'h4444_006C);
    // Redirect to 0x1003 while 4000_0070 is outstanding (3-cycle latency)
    add(1, 0, 0, 0,            0, 0,            1, 32'h4000_0070, 0, 0, 0,            0);
    add(1, 0, 1, 32'h0000_1003, 0, 0,           1, 32'h4000_0070, 0, 1, 0,            0);
    add(1, 0, 0, 0,            0, 0,            1, 32'h4000_0070, 0, 0, 0,            0);
    add(1, 0, 0, 0,            1, JUNK,         1, 32'h4000_0070, 0, 0, 0,            0);
    add(1, 0, 0, 0,            1, 32'h5555_1000, 1, 32'h0000_1000, 1, 0, 32'h0000_1000, 32'h5555_1000);
    // Second redirect while squashing, coincident with the stale response
    add(1, 0, 0, 0,            0, 0,            1, 32'h0000_1004, 0, 0, 0,            0);
    add(1, 0, 1, 32'h0000_2000, 0, 0,           1, 32'h0000_1004, 0, 1, 0,            0);
    add(1, 0, 1, 32'h0000_3007, 1, JUNK,        1, 32'h0000_1004, 0, 1, 0,            0);
    add(1, 0, 0, 0,            1, 32'h6666_3004, 1, 32'h0000_3004, 1, 0, 32'h0000_3004, 32'h6666_3004);
    // Redirect + stall + resp together: redirect wins, data dropped
    add(1, 1, 1, 32'h0000_5000, 1, JUNK,        1, 32'h0000_3008, 0, 1, 0,            0);
    add(1, 0, 0, 0,            1, 32'h7777_5000, 1, 32'h0000_5000, 1, 0, 32'h0000_5000, 32'h7777_5000);
    // Redirect out of HOLD discards the buffered word
    add(1, 1, 0, 0,            1, 32'h8888_5004, 1, 32'h0000_5004, 0, 0, 0,            0);
    add(1, 1, 1, 32'hFFFF_FFF9, 0, 0,           0, 0,            0, 1, 0,            0);
    // Wrap-around
    add(1, 0, 0, 0,            1, 32'h9999_FFF8, 1, 32'hFFFF_FFF8, 1, 0, 32'hFFFF_FFF8, 32'h9999_FFF8);
    add(1, 0, 0, 0,            1, 32'hAAAA_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'hAAAA_FFFC);
    add(1, 0, 0, 0,            1, 32'hBBBB_0000, 1, 32'h0000_0000, 1, 0, 32'h0000_0000, 32'hBBBB_0000);
    // Reset mid-request, late response in IDLE ignored
    add(1, 0, 0, 0,            0, 0,            1, 32'h0000_0004, 0, 0, 0,            0);
    add(0, 0, 0, 0,            0, 0,            0, 0,            0, 0, 0,            0);
    add(1, 0, 0, 0,            1, JUNK,         0, 0,            0, 0, 0,            0);
    add(1, 0, 0, 0,            1, 32'hCCCC_0060, 1, 32'h4000_0060, 1, 0, 32'h4000_0060, 32'hCCCC_0060);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst           = vq[i].rst;
      stall_i       = vq[i].stall;
      redirect_i    = vq[i].redir;
      redirect_pc_i = vq[i].rpc;
      imem_resp_i   = vq[i].resp;
      imem_rdata_i  = vq[i].rdata;
      if (vq[i].e_valid) begin
        e.pc    = vq[i].e_pc;
        e.instr = vq[i].e_instr;
        sb.push_back(e);
      end
      #1;
      chk("read",  i, 32'(imem_read_o), 32'(vq[i].e_read));
      chk("valid", i, 32'(if_valid_o),  32'(vq[i].e_valid));
      chk("flush", i, 32'(if_flush_o),  32'(vq[i].e_flush));
      if (vq[i].e_read) chk("addr", i, imem_address_o, vq[i].e_addr);
      if (if_valid_o) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_valid", i, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_pc",    i, if_pc_o,    e.pc);
          chk("sb_instr", i, if_instr_o, e.instr);
        end
      end
    end

    @(negedge clk);
    imem_resp_i = 1'b0;
    chk("sb_leftover", vq.size(), 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
